alu_mul_sequencer: RTL

- Multi-cycle controller that computes an unsigned 8x8 -> 16-bit product by sequencing the shared 16-bit ALU through shift-and-add steps.
- Owns the ALU's operand, FunSel and WF inputs while busy and reads ALUOut back combinationally.
- Sits beside the ALU in the datapath; the control unit issues Start and waits for Done.

---
 rtl/alu_mul_sequencer.sv | 119 +++++++++++
 1 files changed

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add unsigned multiplier that drives the shared 16-bit ALU.
// It issues an add step and then a shift step for each multiplier bit, and pulses Done when the product is ready.
module alu_mul_sequencer #(
    parameter int N_BITS = 8
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [7:0]  MulA,
    input  logic [7:0]  MulB,
    output logic        Busy,
    output logic        Done,
    output logic [15:0] Product,
    output logic [15:0] ALU_A,
    output logic [15:0] ALU_B,
    output logic [4:0]  ALU_FunSel,
    output logic        ALU_WF,
    input  logic [15:0] ALUOut,
    input  logic [3:0]  ALUFlags
);

    localparam logic [4:0] FS_PASS_A = 5'b10000;
    localparam logic [4:0] FS_ADD    = 5'b10100;
    localparam logic [4:0] FS_LSL    = 5'b11011;
    localparam logic [3:0] LAST_CNT  = 4'(N_BITS - 1);

    typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

    state_t              state;
    logic [15:0]         P;
    logic [15:0]         M;
    logic [N_BITS-1:0]   Q;
    logic [N_BITS-1:0]   q_next;
    logic [3:0]          Cnt;
    logic [15:0]         mula_ext;
    logic [N_BITS-1:0]   mulb_cut;
    logic                unused_inputs;

    always_comb begin
        q_next   = Q >> 1;
        mula_ext = 16'(MulA[N_BITS-1:0]);
        mulb_cut = MulB[N_BITS-1:0];
    end

    // The flags and the operand bits above N_BITS are intentionally not read.
    assign unused_inputs = ^{ALUFlags, MulA, MulB};

    // The ALU outputs are registered. Each transition therefore loads the operands that the next state needs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= IDLE;
            P          <= '0;
            M          <= '0;
            Q          <= '0;
            Cnt        <= '0;
            Product    <= '0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            ALU_A      <= '0;
            ALU_B      <= '0;
            ALU_FunSel <= FS_PASS_A;
            ALU_WF     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        P          <= '0;
                        M          <= mula_ext;
                        Q          <= mulb_cut;
                        Cnt        <= '0;
                        state      <= ADD;
                        Busy       <= 1'b1;
                        ALU_A      <= '0;
                        ALU_B      <= mula_ext;
                        ALU_FunSel <= FS_ADD;
                        ALU_WF     <= mulb_cut[0];
                    end
                end
                ADD: begin
                    if (Q[0])
                        P <= ALUOut;
                    state      <= SHIFT;
                    ALU_A      <= M;
                    ALU_B      <= '0;
                    ALU_FunSel <= FS_LSL;
                    ALU_WF     <= 1'b0;
                end
                SHIFT: begin
                    M   <= ALUOut;
                    Q   <= q_next;
                    Cnt <= Cnt + 4'd1;
                    if (Cnt == LAST_CNT) begin
                        state      <= DONE;
                        Product    <= P;
                        Busy       <= 1'b0;
                        Done       <= 1'b1;
                        ALU_A      <= '0;
                        ALU_B      <= '0;
                        ALU_FunSel <= FS_PASS_A;
                        ALU_WF     <= 1'b0;
                    end else begin
                        // The next add uses the freshly shifted multiplicand, which comes straight from ALUOut.
                        state      <= ADD;
                        ALU_A      <= P;
                        ALU_B      <= ALUOut;
                        ALU_FunSel <= FS_ADD;
                        ALU_WF     <= q_next[0];
                    end
                end
                DONE: begin
                    Done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
